// File: rtl/ex_mdu_if.sv
// Execute-stage multiply/divide unit bus: operation request from the
// pipeline, stall request back to it, and the HI/LO result registers.
interface ex_mdu_if #(
    parameter int W = 32
);
    logic [2:0]   op_i;
    logic [W-1:0] data1_i;
    logic [W-1:0] data2_i;
    logic         flush_i;
    logic         stall_req_o;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;
    logic         div_zero_o;

    modport master (
        output op_i, data1_i, data2_i, flush_i,
        input  stall_req_o, hi_o, lo_o, div_zero_o
    );

    modport slave (
        input  op_i, data1_i, data2_i, flush_i,
        output stall_req_o, hi_o, lo_o, div_zero_o
    );
endinterface

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit owning HI/LO.
// Single-cycle multiply and MTHI/MTLO; restoring radix-2 divider that
// stalls the pipeline for W+1 cycles and writes HI/LO on its DONE edge.
//
// state | meaning
// IDLE  | accepts a new op; MULT/MT* complete here, DIV/DIVU latch operands
// BUSY  | one restoring divide step per cycle, counter W down to 1
// DONE  | stall released; quotient/remainder (or div-by-zero result) written
module ex_mdu #(
    parameter int W = 32
) (
    input logic     clk,
    input logic     rst,
    ex_mdu_if.slave mdu
);
    localparam int CW = $clog2(W + 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic [W:0]    rem;      // partial remainder, one bit wider than operands
    logic [W-1:0]  dvd;      // dividend shifting out, quotient shifting in
    logic [W-1:0]  dvs;
    logic [CW-1:0] cnt;
    logic          neg_q;
    logic          neg_r;
    logic          dz;

    logic          div_start;
    logic          sign1;
    logic          sign2;
    logic [W-1:0]  mag1;
    logic [W-1:0]  mag2;
    logic [2*W-1:0] ext1;
    logic [2*W-1:0] ext2;
    logic [2*W-1:0] product;
    logic [W:0]    rem_sh;
    logic          fits;
    logic [W:0]    rem_nx;
    logic [W-1:0]  dvd_nx;
    logic [W-1:0]  q_res;
    logic [W-1:0]  r_res;

    // Operand conditioning, one restoring step, and result sign fix-up.
    always_comb begin
        div_start = (state == IDLE) && ((mdu.op_i == OP_DIV) || (mdu.op_i == OP_DIVU));

        sign1 = (mdu.op_i == OP_DIV) && mdu.data1_i[W-1];
        sign2 = (mdu.op_i == OP_DIV) && mdu.data2_i[W-1];
        mag1  = sign1 ? -mdu.data1_i : mdu.data1_i;
        mag2  = sign2 ? -mdu.data2_i : mdu.data2_i;

        if (mdu.op_i == OP_MULT) begin
            ext1 = {{W{mdu.data1_i[W-1]}}, mdu.data1_i};
            ext2 = {{W{mdu.data2_i[W-1]}}, mdu.data2_i};
        end else begin
            ext1 = {{W{1'b0}}, mdu.data1_i};
            ext2 = {{W{1'b0}}, mdu.data2_i};
        end
        product = ext1 * ext2;

        rem_sh = {rem[W-1:0], dvd[W-1]};
        fits   = rem_sh >= {1'b0, dvs};
        rem_nx = fits ? (rem_sh - {1'b0, dvs}) : rem_sh;
        dvd_nx = {dvd[W-2:0], fits};

        q_res = neg_q ? -dvd : dvd;
        r_res = neg_r ? -rem[W-1:0] : rem[W-1:0];
    end

    // Stall while a divide is being accepted or iterating; never during reset or flush.
    always_comb begin
        mdu.stall_req_o = !rst && !mdu.flush_i && ((state == BUSY) || div_start);
    end

    // Controller FSM with HI/LO and div-by-zero pulse as registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            mdu.hi_o       <= '0;
            mdu.lo_o       <= '0;
            mdu.div_zero_o <= 1'b0;
            rem            <= '0;
            dvd            <= '0;
            dvs            <= '0;
            cnt            <= '0;
            neg_q          <= 1'b0;
            neg_r          <= 1'b0;
            dz             <= 1'b0;
        end else begin
            mdu.div_zero_o <= 1'b0;
            if (mdu.flush_i) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        case (mdu.op_i)
                            OP_MULT, OP_MULTU: {mdu.hi_o, mdu.lo_o} <= product;
                            OP_MTHI:           mdu.hi_o <= mdu.data1_i;
                            OP_MTLO:           mdu.lo_o <= mdu.data1_i;
                            OP_DIV, OP_DIVU: begin
                                dvs   <= mag2;
                                rem   <= '0;
                                cnt   <= CW'(W);
                                neg_q <= sign1 ^ sign2;
                                neg_r <= sign1;
                                if (mdu.data2_i == '0) begin
                                    // raw dividend kept so HI can return it unchanged
                                    dvd   <= mdu.data1_i;
                                    dz    <= 1'b1;
                                    state <= DONE;
                                end else begin
                                    dvd   <= mag1;
                                    dz    <= 1'b0;
                                    state <= BUSY;
                                end
                            end
                            default: ;
                        endcase
                    end
                    BUSY: begin
                        rem <= rem_nx;
                        dvd <= dvd_nx;
                        cnt <= cnt - 1'b1;
                        if (cnt == CW'(1)) begin
                            state <= DONE;
                        end
                    end
                    DONE: begin
                        if (dz) begin
                            mdu.lo_o       <= '1;
                            mdu.hi_o       <= dvd;
                            mdu.div_zero_o <= 1'b1;
                        end else begin
                            mdu.lo_o <= q_res;
                            mdu.hi_o <= r_res;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ex_mdu.sv
// Bench for ex_mdu: directed vector table, flush/reset/back-to-back
// sequences, then random ops checked against an arithmetic reference model.
module tb_ex_mdu;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_mdu_if #(.W(W)) bus ();
    ex_mdu #(.W(W)) dut (.clk(clk), .rst(rst), .mdu(bus.slave));

    int total = 0;
    int bad   = 0;
    logic [31:0] cur_hi, cur_lo;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] hi;
        logic [31:0] lo;
        int          stall;
        logic        dz;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: HI/LO effect of one op computed with plain 64-bit arithmetic.
    function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                      inout logic [31:0] hi, inout logic [31:0] lo,
                                      output int stall, output logic dz);
        longint sa, sb, p, q, r;
        longint unsigned ua, ub, up;
        stall = 0;
        dz    = 1'b0;
        case (op)
            3'd1: begin sa = $signed(a); sb = $signed(b); p = sa * sb; {hi, lo} = p; end
            3'd2: begin ua = a; ub = b; up = ua * ub; {hi, lo} = up; end
            3'd3, 3'd4: begin
                if (b == 0) begin
                    stall = 1; dz = 1'b1; hi = a; lo = 32'hFFFF_FFFF;
                end else begin
                    stall = W + 1;
                    if (op == 3'd3) begin sa = $signed(a); sb = $signed(b); end
                    else begin sa = a; sb = b; end
                    q = sa / sb;
                    r = sa % sb;
                    lo = q[31:0];
                    hi = r[31:0];
                end
            end
            3'd5: hi = a;
            3'd6: lo = a;
            default: ;
        endcase
    endfunction

    // Present an op right after a falling edge, count stall cycles, check results.
    task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input int estall, input logic edz);
        int cnt;
        bus.op_i    = op;
        bus.data1_i = a;
        bus.data2_i = b;
        #1;
        cnt = 0;
        while (bus.stall_req_o === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        chk({nm, " stall_cycles"}, 64'(cnt), 64'(estall));
        chk({nm, " hi_before_write"}, 64'(bus.hi_o), 64'(cur_hi));
        chk({nm, " lo_before_write"}, 64'(bus.lo_o), 64'(cur_lo));
        @(negedge clk);
        bus.op_i = 3'd0;
        chk({nm, " hi"}, 64'(bus.hi_o), 64'(ehi));
        chk({nm, " lo"}, 64'(bus.lo_o), 64'(elo));
        chk({nm, " div_zero"}, 64'(bus.div_zero_o), 64'(edz));
        cur_hi = ehi;
        cur_lo = elo;
    endtask

    vec_t vecs[10];

    initial begin
        int st;
        logic dz;
        logic [31:0] mh, ml, a, b;
        logic [2:0] op;

        vecs[0] = '{3'd1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, 1'b0};
        vecs[1] = '{3'd2, 32'hFFFF_FFFD, 32'h0000_0005, 32'h0000_0004, 32'hFFFF_FFF1, 0, 1'b0};
        vecs[2] = '{3'd4, 32'd100,       32'd7,         32'd2,         32'd14,        33, 1'b0};
        vecs[3] = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33, 1'b0};
        vecs[4] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, 1'b0};
        vecs[5] = '{3'd3, 32'h1234_5678, 32'h0,         32'h1234_5678, 32'hFFFF_FFFF, 1, 1'b1};
        vecs[6] = '{3'd0, 32'hDEAD_BEEF, 32'h1,         32'h1234_5678, 32'hFFFF_FFFF, 0, 1'b0};
        vecs[7] = '{3'd7, 32'hDEAD_BEEF, 32'h1,         32'h1234_5678, 32'hFFFF_FFFF, 0, 1'b0};
        vecs[8] = '{3'd5, 32'hAAAA_0000, 32'h0,         32'hAAAA_0000, 32'hFFFF_FFFF, 0, 1'b0};
        vecs[9] = '{3'd6, 32'h0000_5555, 32'h0,         32'hAAAA_0000, 32'h0000_5555, 0, 1'b0};

        // reset with a divide presented: no stall, registers cleared
        rst = 1'b1;
        bus.op_i = 3'd4;
        bus.data1_i = 32'd100;
        bus.data2_i = 32'd7;
        bus.flush_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset stall", 64'(bus.stall_req_o), 64'd0);
        chk("reset hi", 64'(bus.hi_o), 64'd0);
        chk("reset lo", 64'(bus.lo_o), 64'd0);
        chk("reset div_zero", 64'(bus.div_zero_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.op_i = 3'd0;
        cur_hi = '0;
        cur_lo = '0;

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].d1, vecs[i].d2,
                   vecs[i].hi, vecs[i].lo, vecs[i].stall, vecs[i].dz);
        end

        // flush on BUSY cycle 10 leaves HI/LO at MTHI/MTLO values
        bus.op_i = 3'd4;
        bus.data1_i = 32'd1000;
        bus.data2_i = 32'd3;
        repeat (10) @(negedge clk);
        bus.flush_i = 1'b1;
        #1;
        chk("flush stall", 64'(bus.stall_req_o), 64'd0);
        @(negedge clk);
        bus.flush_i = 1'b0;
        bus.op_i = 3'd0;
        #1;
        chk("flush idle stall", 64'(bus.stall_req_o), 64'd0);
        repeat (W + 4) @(negedge clk);
        chk("flush hi", 64'(bus.hi_o), 64'(32'hAAAA_0000));
        chk("flush lo", 64'(bus.lo_o), 64'(32'h0000_5555));
        chk("flush div_zero", 64'(bus.div_zero_o), 64'd0);

        // reset mid-divide discards it
        bus.op_i = 3'd4;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst stall", 64'(bus.stall_req_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.op_i = 3'd0;
        #1;
        chk("midrst idle stall", 64'(bus.stall_req_o), 64'd0);
        repeat (W + 4) @(negedge clk);
        chk("midrst hi", 64'(bus.hi_o), 64'd0);
        chk("midrst lo", 64'(bus.lo_o), 64'd0);
        cur_hi = '0;
        cur_lo = '0;

        // back-to-back divides, second accepted the cycle after DONE
        run_op("b2b_first", 3'd4, 32'd9, 32'd2, 32'd1, 32'd4, 33, 1'b0);
        run_op("b2b_second", 3'd4, 32'd10, 32'd3, 32'd1, 32'd3, 33, 1'b0);

        // randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: a = 32'h8000_0000;
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            mh = cur_hi;
            ml = cur_lo;
            ref_model(op, a, b, mh, ml, st, dz);
            run_op($sformatf("rnd%0d op%0d", i, op), op, a, b, mh, ml, st, dz);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ex_mdu.md
# ex_mdu

Execute-stage multiply/divide unit for the MIPS pipeline, parametrised in datapath width. Sits beside the ALU in the EX stage and owns the HI/LO register pair. Single-cycle signed/unsigned multiply, MTHI/MTLO writes, and an iterative radix-2 divider that holds the pipeline through a stall request. Results are exposed continuously on `hi_o`/`lo_o` for MFHI/MFLO forwarding.

## Interface
- `W`, 32: operand width. Legal range is 8..64. HI and LO are each `W` bits.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `op_i`  in  3  operation code:
  - 000 NOP
  - 001 MULT
  - 010 MULTU
  - 011 DIV
  - 100 DIVU
  - 101 MTHI
  - 110 MTLO
  - 111 reserved, treated as NOP.
- `data1_i`  in  W  operand 1 (dividend / multiplicand / MTHI-MTLO source).
- `data2_i`  in  W  operand 2 (divisor / multiplier).
- `flush_i`  in  1  pipeline flush. Aborts any in-flight divide and suppresses any write this cycle.
- `stall_req_o`  out  1  combinational request to freeze IF..EX. Upstream holds `op_i`/`data*_i` stable while it is high.
- `hi_o`  out  W  HI register.
- `lo_o`  out  W  LO register.
- `div_zero_o`  out  1  one-cycle pulse, registered, when a divide by zero completes.

## Operation
- **FSM states:** IDLE, BUSY, DONE.
- **MULT/MULTU (IDLE, no flush):**
  - `{HI,LO}` gets the 2W-bit product at the edge.
  - MULT is signed × signed; MULTU is unsigned × unsigned.
  - No stall.
- **MTHI/MTLO:** HI (respectively LO) gets `data1_i` at the edge. The other register is unchanged.
- **DIV/DIVU in IDLE:**
  - `stall_req_o`=1 combinationally.
  - At the edge, latch |dividend| and |divisor| (DIV: magnitude of the two's complement value; DIVU: raw), plus the quotient and remainder signs.
  - Clear the partial remainder and load counter = W, then go to BUSY.
  - If the divisor is 0, go to DONE directly with the zero flag set.
- **BUSY:**
  - `stall_req_o`=1.
  - Each cycle performs one restoring step: shift the remainder left, bring in the dividend MSB, trial-subtract, set the quotient bit, decrement the counter.
  - When the counter reaches 1, the next state is DONE.
- **DONE:**
  - `stall_req_o`=0, so the pipeline advances this edge.
  - At the edge write LO = quotient, negated if `sign1 xor sign2` (DIV only).
  - Write HI = remainder, negated if `sign1` (DIV only).
  - Next state is IDLE.
- **Divide by zero:**
  - LO = all ones.
  - HI = `data1_i` as latched.
  - `div_zero_o`=1 for the cycle after the DONE edge.
- **Overflow case:** DIV of the most negative value by −1 gives quotient = most negative value and remainder = 0. This falls out of the magnitude arithmetic and needs no special case.
- **Width rules:**
  - Internal remainder is W+1 bits.
  - Negation is W-bit two's complement, wrap-around.
  - Product is computed at 2W bits; MULT sign-extends its operands first.
- **Flush:**
  - In any state, `flush_i`=1 forces IDLE at the edge with no HI/LO write.
  - `stall_req_o` is forced 0 in that cycle.
  - A MULT/MT* op with flush does not write.
- **Reset:**
  - `hi_o`=0, `lo_o`=0, `div_zero_o`=0, FSM=IDLE.
  - `stall_req_o` is 0 while `rst`=1.
  - Reset mid-divide discards the divide.
- **Simultaneous events:**
  - Flush has priority over op, and reset has priority over flush.
  - A new op is accepted only in IDLE; in BUSY/DONE, `op_i` is ignored apart from being held stable by the upstream stall.

## Timing
- MULT/MULTU/MTHI/MTLO: HI/LO are visible on `hi_o`/`lo_o` one cycle after the op is presented.
- DIV/DIVU, nonzero divisor:
  - `stall_req_o` is high for W+1 consecutive cycles (IDLE cycle plus W BUSY cycles).
  - DONE lasts one cycle.
  - Results are visible W+2 cycles after first presentation: 34 for W=32.
- DIV by zero: stall is high 1 cycle; results are visible 2 cycles after presentation; `div_zero_o` is high in that same cycle.
- A back-to-back divide starts in the cycle after DONE (IDLE), with no extra bubble.
- `hi_o`, `lo_o` and `div_zero_o` are registered. `stall_req_o` is combinational from state, `op_i`, `flush_i` and `rst`.

## Test plan
- Reset, then MULT 0xFFFFFFFD × 0x00000005 → next cycle HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULTU with the same operands → HI=0x00000004, LO=0xFFFFFFF1.
- DIVU 100 / 7 → `stall_req_o` high exactly 33 cycles; HI=2, LO=14 at cycle 34; `div_zero_o` stays 0.
- DIV 7 / −2 → LO=0xFFFFFFFD, HI=0x00000001. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIV 0x12345678 / 0 → stall 1 cycle; HI=0x12345678, LO=0xFFFFFFFF; `div_zero_o` pulses one cycle.
- Start DIVU, assert `flush_i` on BUSY cycle 10 → `stall_req_o` drops that cycle; HI/LO keep the prior MTHI 0xAAAA0000 / MTLO 0x5555 values. Repeat with `rst` mid-divide → HI=LO=0, IDLE.
- Two back-to-back DIVU ops (9/2, then 10/3) → HI/LO read 1/4, then 1/3. The second op's stall starts in the cycle after the first op's DONE.
